// File: rtl/bp_me_stream_merge_n.sv
// bp_me_stream_merge_n
// Merges num_ch_p BedRock stream command channels onto one memory command
// port and steers the in-order memory responses back to the issuing channel.
// Whole packets are arbitrated round-robin, and a small order FIFO tracks the
// channel ID of every packet still awaiting its response. It also limits the
// number of outstanding requests.
//
// Ports:
//   clk_i / reset_i          clock, synchronous active-high reset
//   ch_cmd_*                 per-channel command streams (flattened, ch0 in LSBs)
//   ch_resp_*                response stream; header/data/last broadcast,
//                            valid only on the owning channel
//   mem_cmd_*                merged command stream to memory
//   mem_resp_*               response stream from memory (returned in order)
//   outstanding_o            packets issued whose final response beat is pending
module bp_me_stream_merge_n #(
  parameter int unsigned num_ch_p          = 2,
  parameter int unsigned header_width_p    = 128,
  parameter int unsigned data_width_p      = 64,
  parameter int unsigned max_outstanding_p = 4
) (
  input  logic                                 clk_i,
  input  logic                                 reset_i,

  input  logic [num_ch_p*header_width_p-1:0]   ch_cmd_header_i,
  input  logic [num_ch_p*data_width_p-1:0]     ch_cmd_data_i,
  input  logic [num_ch_p-1:0]                  ch_cmd_v_i,
  input  logic [num_ch_p-1:0]                  ch_cmd_last_i,
  output logic [num_ch_p-1:0]                  ch_cmd_ready_and_o,

  output logic [num_ch_p*header_width_p-1:0]   ch_resp_header_o,
  output logic [num_ch_p*data_width_p-1:0]     ch_resp_data_o,
  output logic [num_ch_p-1:0]                  ch_resp_v_o,
  output logic [num_ch_p-1:0]                  ch_resp_last_o,
  input  logic [num_ch_p-1:0]                  ch_resp_ready_and_i,

  output logic [header_width_p-1:0]            mem_cmd_header_o,
  output logic [data_width_p-1:0]              mem_cmd_data_o,
  output logic                                 mem_cmd_v_o,
  output logic                                 mem_cmd_last_o,
  input  logic                                 mem_cmd_ready_and_i,

  input  logic [header_width_p-1:0]            mem_resp_header_i,
  input  logic [data_width_p-1:0]              mem_resp_data_i,
  input  logic                                 mem_resp_v_i,
  input  logic                                 mem_resp_last_i,
  output logic                                 mem_resp_ready_and_o,

  output logic [$clog2(max_outstanding_p+1)-1:0] outstanding_o
);

  localparam int unsigned ch_w_lp  = (num_ch_p > 1) ? $clog2(num_ch_p) : 1;
  localparam int unsigned ptr_w_lp = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1;
  localparam int unsigned cnt_w_lp = $clog2(max_outstanding_p+1);

  typedef enum logic [0:0] {
    e_idle   = 1'b0,
    e_locked = 1'b1
  } state_e;

  state_e               state_r, state_n;
  logic [ch_w_lp-1:0]   rr_ptr_r, lock_ch_r;
  logic [ch_w_lp-1:0]   rr_pick, grant;
  logic                 rr_found, grant_v, credit_ok;
  logic                 cmd_fire, push, pop, fifo_empty;

  logic [ch_w_lp-1:0]   fifo_mem [max_outstanding_p];
  logic [ptr_w_lp-1:0]  wr_ptr_r, rd_ptr_r;
  logic [cnt_w_lp-1:0]  count_r;
  logic [ch_w_lp-1:0]   head;

  // Round-robin search starting at rr_ptr_r.
  always_comb begin
    int unsigned idx;
    idx      = 0;
    rr_pick  = '0;
    rr_found = 1'b0;
    for (int unsigned i = 0; i < num_ch_p; i++) begin
      idx = 32'(rr_ptr_r) + i;
      if (idx >= num_ch_p) idx = idx - num_ch_p;
      if (!rr_found && ch_cmd_v_i[ch_w_lp'(idx)]) begin
        rr_found = 1'b1;
        rr_pick  = ch_w_lp'(idx);
      end
    end
  end

  // A pop in the same cycle frees a slot, so a full FIFO can still accept a
  // new packet whenever a final response beat is retiring alongside it.
  assign credit_ok = (count_r < cnt_w_lp'(max_outstanding_p)) || pop;

  // Output / grant logic
  always_comb begin
    grant   = rr_pick;
    grant_v = rr_found && credit_ok;
    if (state_r == e_locked) begin
      grant   = lock_ch_r;
      grant_v = 1'b1;
    end
  end

  assign mem_cmd_header_o = ch_cmd_header_i[32'(grant)*header_width_p +: header_width_p];
  assign mem_cmd_data_o   = ch_cmd_data_i[32'(grant)*data_width_p +: data_width_p];
  assign mem_cmd_last_o   = ch_cmd_last_i[grant];
  assign mem_cmd_v_o      = grant_v && ch_cmd_v_i[grant];

  always_comb begin
    ch_cmd_ready_and_o = '0;
    if (grant_v) ch_cmd_ready_and_o[grant] = mem_cmd_ready_and_i;
  end

  assign cmd_fire = mem_cmd_v_o && mem_cmd_ready_and_i;
  assign push     = cmd_fire && (state_r == e_idle);

  // Next-state logic
  always_comb begin
    state_n = state_r;
    unique case (state_r)
      e_idle:   if (push && !mem_cmd_last_o)    state_n = e_locked;
      e_locked: if (cmd_fire && mem_cmd_last_o) state_n = e_idle;
      default:  state_n = e_idle;
    endcase
  end

  // State register, lock owner and round-robin pointer
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r   <= e_idle;
      lock_ch_r <= '0;
      rr_ptr_r  <= '0;
    end else begin
      state_r <= state_n;
      if (push) begin
        lock_ch_r <= grant;
        rr_ptr_r  <= (32'(grant) == num_ch_p - 1) ? '0 : grant + 1'b1;
      end
    end
  end

  // Order FIFO of channel IDs, one entry per packet awaiting its response
  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr_r] <= grant;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push)
        wr_ptr_r <= (wr_ptr_r == ptr_w_lp'(max_outstanding_p - 1)) ? '0 : wr_ptr_r + 1'b1;
      if (pop)
        rd_ptr_r <= (rd_ptr_r == ptr_w_lp'(max_outstanding_p - 1)) ? '0 : rd_ptr_r + 1'b1;
      unique case ({push, pop})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  assign fifo_empty    = (count_r == '0);
  assign head          = fifo_mem[rd_ptr_r];
  assign outstanding_o = count_r;

  // Response steering to the FIFO head
  always_comb begin
    ch_resp_v_o = '0;
    if (!fifo_empty) ch_resp_v_o[head] = mem_resp_v_i;
  end

  assign mem_resp_ready_and_o = !fifo_empty && ch_resp_ready_and_i[head];
  assign pop                  = mem_resp_v_i && mem_resp_ready_and_o && mem_resp_last_i;

  assign ch_resp_header_o = {num_ch_p{mem_resp_header_i}};
  assign ch_resp_data_o   = {num_ch_p{mem_resp_data_i}};
  assign ch_resp_last_o   = {num_ch_p{mem_resp_last_i}};

  // Memory must never answer a request that was not issued.
  resp_without_request_a: assert property (
    @(posedge clk_i) disable iff (reset_i) !(mem_resp_v_i && fifo_empty));

endmodule
